// File: rtl/audio_parallel_to_serial.sv
// Parallel-to-serial I2S transmitter.
// Takes 16-bit left/right sample pairs through a valid/ready handshake into a
// one-entry buffer and shifts them out MSB first on the falling edge of bck,
// with the standard one-bit I2S delay after each lrck transition.
// HALF_LEN bit-clock slots per channel half-frame (legal range 18..32).
module audio_parallel_to_serial #(
    parameter int HALF_LEN = 20
) (
    input  logic        bck,
    input  logic        rst,
    input  logic [15:0] inl,
    input  logic [15:0] inr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        lrck,
    output logic        dat,
    output logic        underflow
);

    localparam int CW = $clog2(HALF_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          full, full_n;
    logic [15:0]   hold_l, hold_l_n;
    logic [15:0]   hold_r, hold_r_n;
    logic [15:0]   shift_l, shift_l_n;
    logic [15:0]   shift_r, shift_r_n;
    logic          lrck_n;
    logic          dat_n;
    logic          underflow_n;
    logic          accept;
    logic          last_slot;
    logic          data_slot;

    // The buffer can take a new pair whenever it is empty.
    assign in_ready  = !full;
    assign accept    = in_valid && !full;
    assign last_slot = (cnt == CW'(HALF_LEN - 1));
    assign data_slot = (cnt_n >= CW'(1)) && (cnt_n <= CW'(16));

    // Next-state, slot sequencing and serial data selection.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        full_n      = full;
        hold_l_n    = hold_l;
        hold_r_n    = hold_r;
        shift_l_n   = shift_l;
        shift_r_n   = shift_r;
        lrck_n      = lrck;
        dat_n       = 1'b0;
        underflow_n = 1'b0;

        case (state)
            IDLE: begin
                lrck_n = 1'b1;
                if (full) begin
                    state_n   = LEFT;
                    cnt_n     = '0;
                    lrck_n    = 1'b0;
                    shift_l_n = hold_l;
                    shift_r_n = hold_r;
                    full_n    = 1'b0;
                end else if (accept) begin
                    full_n   = 1'b1;
                    hold_l_n = inl;
                    hold_r_n = inr;
                end
            end

            LEFT, RIGHT: begin
                if (last_slot) begin
                    cnt_n = '0;
                    if (state == LEFT) begin
                        state_n = RIGHT;
                        lrck_n  = 1'b1;
                        if (accept) begin
                            full_n   = 1'b1;
                            hold_l_n = inl;
                            hold_r_n = inr;
                        end
                    end else begin
                        // Frame start: buffered pair first, then a direct
                        // bypass of the offered pair, otherwise a silent frame.
                        state_n = LEFT;
                        lrck_n  = 1'b0;
                        if (full) begin
                            shift_l_n = hold_l;
                            shift_r_n = hold_r;
                            full_n    = 1'b0;
                        end else if (in_valid) begin
                            shift_l_n = inl;
                            shift_r_n = inr;
                        end else begin
                            shift_l_n   = '0;
                            shift_r_n   = '0;
                            underflow_n = 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (accept) begin
                        full_n   = 1'b1;
                        hold_l_n = inl;
                        hold_r_n = inr;
                    end
                    if (data_slot) begin
                        if (state == LEFT) begin
                            dat_n     = shift_l[15];
                            shift_l_n = {shift_l[14:0], 1'b0};
                        end else begin
                            dat_n     = shift_r[15];
                            shift_r_n = {shift_r[14:0], 1'b0};
                        end
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                lrck_n  = 1'b1;
            end
        endcase
    end

    // State and output registers, updated on the falling edge of bck.
    always_ff @(negedge bck or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            full      <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            shift_l   <= '0;
            shift_r   <= '0;
            lrck      <= 1'b1;
            dat       <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            full      <= full_n;
            hold_l    <= hold_l_n;
            hold_r    <= hold_r_n;
            shift_l   <= shift_l_n;
            shift_r   <= shift_r_n;
            lrck      <= lrck_n;
            dat       <= dat_n;
            underflow <= underflow_n;
        end
    end

endmodule
